esfa_test_sequencer: RTL and testbench

- Self-checking test-program controller for the ESFA datapath on the FPGA board.
- Walks the instruction ROM and issues each instruction to the ESFA design, honouring ROM and design latency.
- Checks assert-flagged instructions against the design's result outputs.
- Reports a verdict over the UART transmit handshake; replaces ad-hoc counter logic in the top level with a defined FSM.

---
 rtl/esfa_pkg.sv | 37 +++
 rtl/esfa_uart_reporter.sv | 104 ++++++++++
 rtl/esfa_test_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_esfa_test_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esfa_pkg.sv
// Shared constants for the ESFA test sequencer: instruction field positions,
// report status bytes, UART timeout and FSM state encodings.
package esfa_pkg;

    localparam int INSTR_W      = 56;
    localparam int F_WILL_WRITE = 0;
    localparam int F_INDEX_LSB  = 8;
    localparam int F_VALUE_LSB  = 16;
    localparam int F_META_LSB   = 24;
    localparam int F_IS_META    = 32;
    localparam int F_SEL_LSB    = 40;
    localparam int F_ASSERT     = 48;

    localparam logic [7:0] STAT_PASS = 8'h50;
    localparam logic [7:0] STAT_FAIL = 8'h46;

    localparam int TX_TIMEOUT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_RES,
        S_CHECK,
        S_REPORT,
        S_DONE
    } seq_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_SEND,
        R_WAIT_HI,
        R_WAIT_LO,
        R_FIN
    } rep_state_t;

endpackage

// File: rtl/esfa_uart_reporter.sv
// Sends up to three bytes over the tx_start/tx_busy UART handshake and pulses
// done when finished; a byte whose tx_busy never rises is dropped after TX_TIMEOUT cycles.
module esfa_uart_reporter
    import esfa_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic [7:0] byte2,
    input  logic [1:0] count,
    input  logic       tx_busy,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic       done
);

    rep_state_t state, next_state;
    logic [7:0] b0_q, b1_q, b2_q;
    logic [1:0] cnt_q;
    logic [1:0] idx;
    logic [4:0] timer;
    logic       last_byte;
    logic       byte_done;

    assign last_byte = (idx == cnt_q - 2'd1);
    assign byte_done = ((state == R_WAIT_HI) && !tx_busy && (timer == 5'(TX_TIMEOUT - 1)))
                     || ((state == R_WAIT_LO) && !tx_busy);

    always_comb begin
        case (idx)
            2'd0:    tx_byte = b0_q;
            2'd1:    tx_byte = b1_q;
            default: tx_byte = b2_q;
        endcase
    end

    always_comb begin
        next_state = state;
        tx_start   = 1'b0;
        done       = 1'b0;
        case (state)
            R_IDLE: begin
                if (go) begin
                    next_state = (count == 2'd0) ? R_FIN : R_SEND;
                end
            end
            R_SEND: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    next_state = R_WAIT_HI;
                end
            end
            R_WAIT_HI: begin
                if (tx_busy) begin
                    next_state = R_WAIT_LO;
                end else if (byte_done) begin
                    next_state = last_byte ? R_FIN : R_SEND;
                end
            end
            R_WAIT_LO: begin
                if (byte_done) begin
                    next_state = last_byte ? R_FIN : R_SEND;
                end
            end
            R_FIN: begin
                done       = 1'b1;
                next_state = R_IDLE;
            end
            default: next_state = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= R_IDLE;
            b0_q  <= '0;
            b1_q  <= '0;
            b2_q  <= '0;
            cnt_q <= '0;
            idx   <= '0;
            timer <= '0;
        end else begin
            state <= next_state;
            if (state == R_IDLE && go) begin
                b0_q  <= byte0;
                b1_q  <= byte1;
                b2_q  <= byte2;
                cnt_q <= count;
                idx   <= '0;
            end else if (byte_done && !last_byte) begin
                idx <= idx + 2'd1;
            end
            // Timer counts cycles since the tx_start pulse while waiting for tx_busy.
            if (state == R_WAIT_HI) begin
                timer <= timer + 5'd1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/esfa_test_sequencer.sv
// Walks the instruction ROM, drives the ESFA design, checks asserted results
// and reports a verdict over UART. ESFA_SEQ_CONTINUE_EN keeps running past mismatches.
module esfa_test_sequencer
    import esfa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_INSTR = 256,
    parameter int ROM_LAT   = 1,
    parameter int DUT_LAT   = 1
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [55:0]       rom_data,
    output logic              dut_will_write,
    output logic [7:0]        dut_new_index,
    output logic [7:0]        dut_new_value,
    output logic [7:0]        dut_selector,
    output logic [7:0]        dut_metadata,
    output logic              dut_is_metadata,
    input  logic              dut_result_bool,
    input  logic [7:0]        dut_result_value,
    output logic [7:0]        tx_byte,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              pass,
    output logic              fail,
`ifdef ESFA_SEQ_CONTINUE_EN
    output logic [7:0]        fail_count,
`endif
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_INSTR - 1);

    seq_state_t state, next_state;
    logic [ADDR_W:0] cnt;
    logic [2:0]      lat;
    logic            hold_lat;
    logic [7:0]      index_q, value_q, sel_q, meta_q;
    logic            is_meta_q, assert_q;
    logic            mismatch;
    logic            in_issue;
    logic            rep_go, rep_done;
    logic [7:0]      rep_byte0, rep_byte1, rep_byte2;
    logic [1:0]      rep_count;
    logic            unused_bits;

    assign unused_bits = ^{rom_data[7:1], rom_data[39:33], rom_data[55:49]};

    assign rom_addr = cnt[ADDR_W-1:0];
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign in_issue = (state == S_ISSUE);

    // During ISSUE the fields come straight from the ROM; afterwards the captured copy holds them.
    assign dut_will_write  = in_issue & rom_data[F_WILL_WRITE];
    assign dut_new_index   = in_issue ? rom_data[F_INDEX_LSB +: 8] : index_q;
    assign dut_new_value   = in_issue ? rom_data[F_VALUE_LSB +: 8] : value_q;
    assign dut_selector    = in_issue ? rom_data[F_SEL_LSB +: 8]   : sel_q;
    assign dut_metadata    = in_issue ? rom_data[F_META_LSB +: 8]  : meta_q;
    assign dut_is_metadata = in_issue ? rom_data[F_IS_META]        : is_meta_q;

    assign mismatch = assert_q && ((dut_result_bool != is_meta_q) || (dut_result_value != meta_q));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (NUM_INSTR == 0) ? S_REPORT : S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat == 3'(ROM_LAT - 1)) next_state = S_ISSUE;
            end
            S_ISSUE:  next_state = S_WAIT_RES;
            S_WAIT_RES: begin
                if (lat == 3'(DUT_LAT - 1)) next_state = S_CHECK;
            end
            S_CHECK: begin
`ifdef ESFA_SEQ_CONTINUE_EN
                next_state = (cnt == LAST_IDX) ? S_REPORT : S_FETCH;
`else
                next_state = (mismatch || cnt == LAST_IDX) ? S_REPORT : S_FETCH;
`endif
            end
            S_REPORT: begin
                if (rep_done) next_state = S_DONE;
            end
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    assign hold_lat = ((state == S_FETCH) && (next_state == S_FETCH))
                   || ((state == S_WAIT_RES) && (next_state == S_WAIT_RES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat        <= '0;
            rep_go     <= 1'b0;
            index_q    <= '0;
            value_q    <= '0;
            sel_q      <= '0;
            meta_q     <= '0;
            is_meta_q  <= 1'b0;
            assert_q   <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
`ifdef ESFA_SEQ_CONTINUE_EN
            fail_count <= '0;
`endif
        end else begin
            state  <= next_state;
            lat    <= hold_lat ? lat + 3'd1 : 3'd0;
            rep_go <= (next_state == S_REPORT) && (state != S_REPORT);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        pass      <= (NUM_INSTR == 0);
`ifdef ESFA_SEQ_CONTINUE_EN
                        fail_count <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    index_q   <= rom_data[F_INDEX_LSB +: 8];
                    value_q   <= rom_data[F_VALUE_LSB +: 8];
                    sel_q     <= rom_data[F_SEL_LSB +: 8];
                    meta_q    <= rom_data[F_META_LSB +: 8];
                    is_meta_q <= rom_data[F_IS_META];
                    assert_q  <= rom_data[F_ASSERT];
                end
                S_CHECK: begin
`ifdef ESFA_SEQ_CONTINUE_EN
                    // Only the first mismatch sets fail_addr; later ones just count.
                    if (mismatch) begin
                        if (!fail) begin
                            fail      <= 1'b1;
                            fail_addr <= cnt[ADDR_W-1:0];
                        end
                        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
                    end
                    if (cnt == LAST_IDX) begin
                        pass <= !(fail || mismatch);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    if (mismatch) begin
                        fail      <= 1'b1;
                        fail_addr <= cnt[ADDR_W-1:0];
                    end else if (cnt == LAST_IDX) begin
                        pass <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign rep_byte0 = fail ? STAT_FAIL : STAT_PASS;
    assign rep_byte1 = 8'(fail_addr);
`ifdef ESFA_SEQ_CONTINUE_EN
    assign rep_byte2 = fail_count;
    assign rep_count = 2'd3;
`else
    assign rep_byte2 = 8'h00;
    assign rep_count = 2'd2;
`endif

    esfa_uart_reporter u_reporter (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (rep_go),
        .byte0    (rep_byte0),
        .byte1    (rep_byte1),
        .byte2    (rep_byte2),
        .count    (rep_count),
        .tx_busy  (tx_busy),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .done     (rep_done)
    );

endmodule

// File: tb/tb_esfa_test_sequencer.sv
// Self-checking bench for esfa_test_sequencer: table-driven runs against a ROM,
// ESFA and UART model with scoreboard queues; honours ESFA_SEQ_CONTINUE_EN.
module tb_esfa_test_sequencer;

    typedef struct {
        logic [3:0][55:0] prog;
        logic [7:0]       b0;
        logic [7:0]       b1;
        logic             exp_pass;
        logic             exp_fail;
        logic [7:0]       exp_addr;
        logic [3:0][15:0] wr;
        int               n_stop;
        int               n_all;
        logic [7:0]       cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [55:0] rom_data;
    logic        dut_will_write;
    logic [7:0]  dut_new_index, dut_new_value, dut_selector, dut_metadata;
    logic        dut_is_metadata;
    logic        dut_result_bool;
    logic [7:0]  dut_result_value;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy;
    logic        busy, pass, fail;
    logic [7:0]  fail_addr;
`ifdef ESFA_SEQ_CONTINUE_EN
    logic [7:0]  fail_count;
    logic [7:0]  fail_count_z;
`endif

    logic        start_z = 1'b0;
    logic [7:0]  rom_addr_z;
    logic        ww_z;
    logic [7:0]  idx_z, val_z, sel_z, meta_z;
    logic        ism_z;
    logic [7:0]  tx_byte_z;
    logic        tx_start_z;
    logic        busy_z, pass_z, fail_z;
    logic [7:0]  fail_addr_z;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [55:0] rom [0:3];
    logic [7:0]  mem [0:255];
    logic        mem_clear = 1'b0;
    logic        uart_stuck = 1'b0;
    int          u_cnt;
    logic [7:0]  cur_tx;
    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_wr[$];
    int          pulse_cycles[$];
    int          ww_cycles[$];
    vec_t        vecs [4];

    always #5 clk = ~clk;

    esfa_test_sequencer #(.ADDR_W(8), .NUM_INSTR(4), .ROM_LAT(1), .DUT_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .dut_will_write(dut_will_write), .dut_new_index(dut_new_index),
        .dut_new_value(dut_new_value), .dut_selector(dut_selector),
        .dut_metadata(dut_metadata), .dut_is_metadata(dut_is_metadata),
        .dut_result_bool(dut_result_bool), .dut_result_value(dut_result_value),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .pass(pass), .fail(fail),
`ifdef ESFA_SEQ_CONTINUE_EN
        .fail_count(fail_count),
`endif
        .fail_addr(fail_addr)
    );

    esfa_test_sequencer #(.ADDR_W(8), .NUM_INSTR(0), .ROM_LAT(1), .DUT_LAT(1)) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .start(start_z), .rom_addr(rom_addr_z), .rom_data(56'h0),
        .dut_will_write(ww_z), .dut_new_index(idx_z), .dut_new_value(val_z),
        .dut_selector(sel_z), .dut_metadata(meta_z), .dut_is_metadata(ism_z),
        .dut_result_bool(1'b0), .dut_result_value(8'h00),
        .tx_byte(tx_byte_z), .tx_start(tx_start_z), .tx_busy(1'b0),
        .busy(busy_z), .pass(pass_z), .fail(fail_z),
`ifdef ESFA_SEQ_CONTINUE_EN
        .fail_count(fail_count_z),
`endif
        .fail_addr(fail_addr_z)
    );

    // ROM with one cycle of latency and a small ESFA model: writes fill mem, reads return mem[selector].
    always @(posedge clk) begin
        rom_data <= rom[rom_addr[1:0]];
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (dut_will_write) begin
            mem[dut_new_index] <= dut_new_value;
        end
        dut_result_value <= mem[dut_selector];
        dut_result_bool  <= (mem[dut_selector] != 8'h00);
    end

    // UART model: busy rises two cycles after a request and stays up three cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)             u_cnt <= 0;
        else if (tx_start)      u_cnt <= 5;
        else if (u_cnt != 0)    u_cnt <= u_cnt - 1;
    end
    assign tx_busy = !uart_stuck && (u_cnt >= 1) && (u_cnt <= 3);

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Scoreboard monitor: pops expected bytes on tx_start and expected writes on dut_will_write.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (tx_start) begin
                cur_tx = tx_byte;
                pulse_cycles.push_back(cyc);
                if (exp_bytes.size() == 0) checkOutput("unexpected_tx", {56'h0, tx_byte}, 64'h1FF);
                else                       checkOutput("tx_byte", {56'h0, tx_byte}, {56'h0, exp_bytes.pop_front()});
            end else if (tx_busy) begin
                checkOutput("tx_byte_stable", {56'h0, tx_byte}, {56'h0, cur_tx});
            end
            if (dut_will_write) begin
                ww_cycles.push_back(cyc);
                if (exp_wr.size() == 0) checkOutput("unexpected_write", {48'h0, dut_new_index, dut_new_value}, 64'h1FFFF);
                else                    checkOutput("write", {48'h0, dut_new_index, dut_new_value}, {48'h0, exp_wr.pop_front()});
            end
        end
    end

    function automatic logic [55:0] mk(input logic ww, input logic [7:0] idx, input logic [7:0] val,
                                       input logic [7:0] meta, input logic ism, input logic [7:0] sel,
                                       input logic asrt);
        logic [55:0] w;
        w        = '1;
        w[0]     = ww;
        w[15:8]  = idx;
        w[23:16] = val;
        w[31:24] = meta;
        w[32]    = ism;
        w[47:40] = sel;
        w[48]    = asrt;
        return w;
    endfunction

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 64'(n), 64'(bound + 1));
    endtask

    task automatic flushQueues();
        exp_bytes.delete();
        exp_wr.delete();
        pulse_cycles.delete();
        ww_cycles.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput(name, {2'b0, busy, pass, fail, fail_addr, rom_addr, tx_start, tx_byte, dut_will_write,
                           dut_new_index, dut_new_value, dut_selector, dut_metadata, dut_is_metadata}, 64'h0);
`ifdef ESFA_SEQ_CONTINUE_EN
        checkOutput({name, "_fail_count"}, {56'h0, fail_count}, 64'h0);
`endif
    endtask

    task automatic applyStimulus(input vec_t v);
        int nw;
        flushQueues();
        for (int i = 0; i < 4; i++) rom[i] = v.prog[i];
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
`ifdef ESFA_SEQ_CONTINUE_EN
        nw = v.n_all;
`else
        nw = v.n_stop;
`endif
        for (int i = 0; i < nw; i++) exp_wr.push_back(v.wr[i]);
        exp_bytes.push_back(v.b0);
        exp_bytes.push_back(v.b1);
`ifdef ESFA_SEQ_CONTINUE_EN
        exp_bytes.push_back(v.cnt);
`endif
        pulseStart();
        repeat (3) @(negedge clk);
        pulseStart();
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        waitIdle(600);
        pulseStart();
        repeat (3) @(negedge clk);
        checkOutput({tag, "_start_in_done"}, {63'h0, busy}, 64'h0);
        checkOutput({tag, "_pass"}, {63'h0, pass}, {63'h0, v.exp_pass});
        checkOutput({tag, "_fail"}, {63'h0, fail}, {63'h0, v.exp_fail});
        checkOutput({tag, "_fail_addr"}, {56'h0, fail_addr}, {56'h0, v.exp_addr});
        checkOutput({tag, "_bytes_left"}, 64'(exp_bytes.size()), 64'h0);
        checkOutput({tag, "_writes_left"}, 64'(exp_wr.size()), 64'h0);
`ifdef ESFA_SEQ_CONTINUE_EN
        checkOutput({tag, "_fail_count"}, {56'h0, fail_count}, {56'h0, v.cnt});
`endif
    endtask

    initial begin
        int n;
        int gap;
        logic [7:0] got_z[$];
        int ww_z_count;
        logic seen_busy;

        vecs[0].prog = {mk(1, 8'h04, 8'h77, 8'h00, 0, 8'h00, 0), mk(1, 8'h03, 8'h3C, 8'h00, 0, 8'h00, 0),
                        mk(0, 8'h02, 8'hEE, 8'h00, 0, 8'h00, 0), mk(1, 8'h01, 8'hA5, 8'h00, 0, 8'h00, 0)};
        vecs[0].b0 = 8'h50; vecs[0].b1 = 8'h00; vecs[0].exp_pass = 1; vecs[0].exp_fail = 0; vecs[0].exp_addr = 8'h00;
        vecs[0].wr = {16'h0, 16'h0477, 16'h033C, 16'h01A5}; vecs[0].n_stop = 3; vecs[0].n_all = 3; vecs[0].cnt = 8'h00;

        vecs[1].prog = {mk(1, 8'h09, 8'h99, 8'h00, 0, 8'h00, 0), mk(0, 8'h00, 8'h00, 8'h5A, 1, 8'h07, 1),
                        mk(1, 8'h03, 8'h11, 8'h00, 0, 8'h00, 0), mk(1, 8'h07, 8'h5B, 8'h00, 0, 8'h00, 0)};
        vecs[1].b0 = 8'h46; vecs[1].b1 = 8'h02; vecs[1].exp_pass = 0; vecs[1].exp_fail = 1; vecs[1].exp_addr = 8'h02;
        vecs[1].wr = {16'h0, 16'h0999, 16'h0311, 16'h075B}; vecs[1].n_stop = 2; vecs[1].n_all = 3; vecs[1].cnt = 8'h01;

        vecs[2].prog = {mk(1, 8'h16, 8'h02, 8'h00, 0, 8'h00, 0), mk(0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0),
                        mk(1, 8'h15, 8'h01, 8'h00, 0, 8'h00, 0), mk(0, 8'h00, 8'h00, 8'h00, 1, 8'h14, 1)};
        vecs[2].b0 = 8'h46; vecs[2].b1 = 8'h00; vecs[2].exp_pass = 0; vecs[2].exp_fail = 1; vecs[2].exp_addr = 8'h00;
        vecs[2].wr = {16'h0, 16'h0, 16'h1602, 16'h1501}; vecs[2].n_stop = 0; vecs[2].n_all = 2; vecs[2].cnt = 8'h01;

        vecs[3].prog = {mk(0, 8'h00, 8'h00, 8'h01, 1, 8'h06, 1), mk(0, 8'h00, 8'h00, 8'h10, 1, 8'h05, 1),
                        mk(0, 8'h00, 8'h00, 8'h11, 1, 8'h05, 1), mk(1, 8'h05, 8'h10, 8'h00, 0, 8'h00, 0)};
        vecs[3].b0 = 8'h46; vecs[3].b1 = 8'h01; vecs[3].exp_pass = 0; vecs[3].exp_fail = 1; vecs[3].exp_addr = 8'h01;
        vecs[3].wr = {16'h0, 16'h0, 16'h0, 16'h0510}; vecs[3].n_stop = 1; vecs[3].n_all = 1; vecs[3].cnt = 8'h02;

        for (int i = 0; i < 4; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            runVector(vecs[r], $sformatf("vec%0d", r));
            if (r == 0 && ww_cycles.size() == 3) begin
                checkOutput("issue_spacing", 64'(ww_cycles[2] - ww_cycles[1]), 64'd4);
            end
        end
`ifdef ESFA_SEQ_CONTINUE_EN
        runVector(vecs[3], "continue");
`endif

        // Zero-instruction build: nothing issued, straight to a pass report.
        got_z.delete();
        ww_z_count = 0;
        seen_busy = 1'b0;
        start_z = 1'b1;
        @(negedge clk);
        start_z = 1'b0;
        n = 0;
        while (n < 200 && !(seen_busy && !busy_z)) begin
            if (busy_z) seen_busy = 1'b1;
            if (tx_start_z) got_z.push_back(tx_byte_z);
            if (ww_z) ww_z_count++;
            @(negedge clk);
            n++;
        end
        checkOutput("zero_busy", {63'h0, busy_z}, 64'h0);
        checkOutput("zero_nbytes", 64'(got_z.size()), 64'd2);
        if (got_z.size() == 2) checkOutput("zero_bytes", {48'h0, got_z[0], got_z[1]}, 64'h5000);
        checkOutput("zero_issue", 64'(ww_z_count), 64'h0);
        checkOutput("zero_verdict", {62'h0, pass_z, fail_z}, 64'h2);

        // Reset while waiting for a result.
        flushQueues();
        for (int i = 0; i < 4; i++) rom[i] = vecs[0].prog[i];
        exp_wr.push_back(16'h01A5);
        pulseStart();
        n = 0;
        while (!dut_will_write && n < 100) begin @(negedge clk); n++; end
        checkOutput("first_issue_seen", {63'h0, dut_will_write}, 64'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("reset_in_wait_res");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runVector(vecs[0], "after_reset1");

        // Reset in the middle of transmitting the first report byte.
        flushQueues();
        for (int i = 0; i < 3; i++) exp_wr.push_back(vecs[0].wr[i]);
        exp_bytes.push_back(8'h50);
        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
        pulseStart();
        n = 0;
        while (!tx_start && n < 200) begin @(negedge clk); n++; end
        checkOutput("tx_pulse_seen", {63'h0, tx_start}, 64'h1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetOutputs("reset_in_tx");
        flushQueues();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runVector(vecs[0], "after_reset2");

        // UART that never raises busy: each byte must be abandoned after the timeout.
        uart_stuck = 1'b1;
        runVector(vecs[0], "stuck_uart");
        if (pulse_cycles.size() >= 2) begin
            gap = pulse_cycles[1] - pulse_cycles[0];
            checks++;
            if (gap < 16 || gap > 18) begin
                errors++;
                $display("[TB] FAIL tx_timeout_gap actual=%0d required=16..18", gap);
            end
        end else begin
            checkOutput("tx_timeout_pulses", 64'(pulse_cycles.size()), 64'd2);
        end
        uart_stuck = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
